// File: rtl/max_exp_pkg.sv
// rtl/max_exp_pkg.sv - shared widths, tree geometry helpers and gate-cost constants
package max_exp_pkg;

  localparam int DEF_EXP_MSB = 5;
  localparam int DEF_EW      = DEF_EXP_MSB + 1;

  // Gate-cost weights used for the static size estimate
  localparam int COM6_COST = 18;
  localparam int MX_COST   = 3;
  localparam int FF_COST   = 6;

  // Lane width from the exponent MSB index
  function automatic int lane_width(input int exp_msb);
    return exp_msb + 1;
  endfunction

  // Number of registered comparator levels needed to reduce n lanes to one
  function automatic int tree_depth(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Node count at a given tree level (level 0 is the raw lanes)
  function automatic int level_cnt(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Cost of one two-input max node: comparator in 6-bit slices plus data muxes
  function automatic int cmp2_cost(input int ew, input int iw);
    return COM6_COST * ((ew + 5) / 6) + MX_COST * (ew + iw);
  endfunction

  // Register bits of the whole pipe: tree levels, accumulator, output stage
  function automatic int pipe_reg_bits(input int n, input int ew, input int iw);
    int bits;
    bits = 0;
    for (int l = 1; l <= tree_depth(n); l++) bits += level_cnt(n, l) * (ew + iw) + 2;
    bits += 1 + ew + iw + 8;
    bits += 1 + ew + iw + 8;
    return bits;
  endfunction

endpackage

// File: rtl/max_exp_determ_pipe_if.sv
// rtl/max_exp_determ_pipe_if.sv - beat input / group result handshake bundle
interface max_exp_determ_pipe_if
  import max_exp_pkg::*;
#(
  parameter int EW     = DEF_EW,
  parameter int NUM_IN = 9,
  parameter int IDX_W  = 5
);
  logic                  i_valid;
  logic                  o_ready;
  logic [NUM_IN*EW-1:0]  i_exp;
  logic                  i_last;
  logic                  o_valid;
  logic                  i_ready;
  logic [EW-1:0]         o_max_exp;
  logic [IDX_W-1:0]      o_max_idx;
  logic [7:0]            o_beats;

  modport master (
    output i_valid, i_exp, i_last, i_ready,
    input  o_ready, o_valid, o_max_exp, o_max_idx, o_beats
  );

  modport slave (
    input  i_valid, i_exp, i_last, i_ready,
    output o_ready, o_valid, o_max_exp, o_max_idx, o_beats
  );
endinterface

// File: rtl/max_exp_cmp2.sv
// rtl/max_exp_cmp2.sv - two-input unsigned max node, ties keep the a side
module max_exp_cmp2
  import max_exp_pkg::*;
#(
  parameter int EW    = DEF_EW,
  parameter int IDX_W = 5
) (
  input  logic [EW-1:0]    a_exp,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [EW-1:0]    b_exp,
  input  logic [IDX_W-1:0] b_idx,
  output logic [EW-1:0]    max_exp,
  output logic [IDX_W-1:0] max_idx,
  output logic [50:0]      number
);
  logic take_b;

  // a always carries the lower lane indices, so only a strict win moves to b
  assign take_b  = b_exp > a_exp;
  assign max_exp = take_b ? b_exp : a_exp;
  assign max_idx = take_b ? b_idx : a_idx;
  assign number  = 51'(cmp2_cost(EW, IDX_W));
endmodule

// File: rtl/max_exp_determ_pipe.sv
// rtl/max_exp_determ_pipe.sv - pipelined per-beat max tree with group accumulator
module max_exp_determ_pipe
  import max_exp_pkg::*;
#(
  parameter int FP16_exp_width = 5,
  parameter int NUM_IN         = 9,
  parameter int IDX_W          = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  max_exp_determ_pipe_if.slave  bus,
  output logic [50:0]           number
);
  localparam int EW       = lane_width(FP16_exp_width);
  localparam int D        = tree_depth(NUM_IN);
  localparam int REG_BITS = pipe_reg_bits(NUM_IN, EW, IDX_W);

  logic advance;
  logic accept;

  logic [EW-1:0]    src_exp [D][NUM_IN];
  logic [IDX_W-1:0] src_idx [D][NUM_IN];
  logic [EW-1:0]    nxt_exp [D][NUM_IN];
  logic [IDX_W-1:0] nxt_idx [D][NUM_IN];
  logic [EW-1:0]    stg_exp [D][NUM_IN];
  logic [IDX_W-1:0] stg_idx [D][NUM_IN];
  logic [50:0]      node_num [D][NUM_IN];
  logic [D-1:0]     stg_valid;
  logic [D-1:0]     stg_last;

  logic [EW-1:0]    beat_exp;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_valid;
  logic             beat_last;

  logic             acc_open;
  logic [EW-1:0]    acc_exp;
  logic [IDX_W-1:0] acc_idx;
  logic [7:0]       acc_beats;
  logic [EW-1:0]    merge_exp;
  logic [IDX_W-1:0] merge_idx;
  logic [7:0]       merge_beats;

  logic             out_valid;
  logic [EW-1:0]    out_exp;
  logic [IDX_W-1:0] out_idx;
  logic [7:0]       out_beats;

  // The whole pipe moves only when the output slot is free or being drained
  assign bus.o_ready = !(out_valid && !bus.i_ready);
  assign advance     = bus.o_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  // Comparator tree: level l reduces src[l] into nxt[l]; odd leftovers pass through
  for (genvar l = 0; l < D; l++) begin : g_lvl
    localparam int PC = level_cnt(NUM_IN, l);
    localparam int NC = level_cnt(NUM_IN, l + 1);
    for (genvar j = 0; j < NUM_IN; j++) begin : g_node
      if (l == 0) begin : g_src_in
        assign src_exp[l][j] = bus.i_exp[j*EW +: EW];
        assign src_idx[l][j] = IDX_W'(j);
      end else begin : g_src_stg
        assign src_exp[l][j] = stg_exp[l-1][j];
        assign src_idx[l][j] = stg_idx[l-1][j];
      end
      if (j < NC && (2*j + 1) < PC) begin : g_cmp
        max_exp_cmp2 #(.EW(EW), .IDX_W(IDX_W)) u_cmp (
          .a_exp   (src_exp[l][2*j]),
          .a_idx   (src_idx[l][2*j]),
          .b_exp   (src_exp[l][2*j+1]),
          .b_idx   (src_idx[l][2*j+1]),
          .max_exp (nxt_exp[l][j]),
          .max_idx (nxt_idx[l][j]),
          .number  (node_num[l][j])
        );
      end else if (j < NC) begin : g_pass
        assign nxt_exp[l][j]  = src_exp[l][2*j];
        assign nxt_idx[l][j]  = src_idx[l][2*j];
        assign node_num[l][j] = '0;
      end else begin : g_unused
        assign nxt_exp[l][j]  = '0;
        assign nxt_idx[l][j]  = '0;
        assign node_num[l][j] = '0;
      end
    end
  end

  // Tree level registers with their valid/last bits; frozen during a stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stg_valid <= '0;
      stg_last  <= '0;
      for (int l = 0; l < D; l++) begin
        for (int j = 0; j < NUM_IN; j++) begin
          stg_exp[l][j] <= '0;
          stg_idx[l][j] <= '0;
        end
      end
    end else if (advance) begin
      stg_valid[0] <= accept;
      stg_last[0]  <= accept && bus.i_last;
      for (int l = 1; l < D; l++) begin
        stg_valid[l] <= stg_valid[l-1];
        stg_last[l]  <= stg_last[l-1];
      end
      for (int l = 0; l < D; l++) begin
        for (int j = 0; j < NUM_IN; j++) begin
          stg_exp[l][j] <= nxt_exp[l][j];
          stg_idx[l][j] <= nxt_idx[l][j];
        end
      end
    end
  end

  assign beat_exp   = stg_exp[D-1][0];
  assign beat_idx   = stg_idx[D-1][0];
  assign beat_valid = stg_valid[D-1];
  assign beat_last  = stg_last[D-1];

  // Fold the beat into the running group: first beat loads, later beats need a strict win
  always_comb begin
    merge_exp   = acc_exp;
    merge_idx   = acc_idx;
    merge_beats = acc_beats;
    if (!acc_open || beat_exp > acc_exp) begin
      merge_exp = beat_exp;
      merge_idx = beat_idx;
    end
    if (!acc_open) begin
      merge_beats = 8'd1;
    end else if (acc_beats != 8'hFF) begin
      merge_beats = acc_beats + 8'd1;
    end
  end

  // Accumulator and result slot; a closing beat moves straight into the result slot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_open  <= 1'b0;
      acc_exp   <= '0;
      acc_idx   <= '0;
      acc_beats <= '0;
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_idx   <= '0;
      out_beats <= '0;
    end else if (advance) begin
      out_valid <= 1'b0;
      if (beat_valid) begin
        if (beat_last) begin
          out_valid <= 1'b1;
          out_exp   <= merge_exp;
          out_idx   <= merge_idx;
          out_beats <= merge_beats;
          acc_open  <= 1'b0;
        end else begin
          acc_open  <= 1'b1;
          acc_exp   <= merge_exp;
          acc_idx   <= merge_idx;
          acc_beats <= merge_beats;
        end
      end
    end
  end

  assign bus.o_valid   = out_valid;
  assign bus.o_max_exp = out_exp;
  assign bus.o_max_idx = out_idx;
  assign bus.o_beats   = out_beats;

  // Static size estimate: every node's own figure plus all register bits
  always_comb begin
    number = 51'(REG_BITS * FF_COST);
    for (int l = 0; l < D; l++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        number = number + node_num[l][j];
      end
    end
  end

endmodule

// File: doc/max_exp_determ_pipe.md
MAX_EXP_DETERM_PIPE -- requirements
Module: max_exp_determ_pipe

Interface
REQ-001 SHALL have parameter FP16_exp_width, default 5, meaning exponent MSB index (lane width EW = FP16_exp_width+1).
REQ-002 SHALL have parameter NUM_IN, default 9, meaning exponent lanes per beat (range 2..32).
REQ-003 SHALL have parameter IDX_W, default 5, meaning index width, with $clog2(NUM_IN) <= IDX_W.
REQ-004 SHALL have port i_clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-006 SHALL have port i_valid, input, 1 bit, meaning beat present on i_exp.
REQ-007 SHALL have port o_ready, output, 1 bit, meaning block accepts a beat this cycle.
REQ-008 SHALL have port i_exp, input, NUM_IN*EW bits, meaning lane k at bits [k*EW +: EW].
REQ-009 SHALL have port i_last, input, 1 bit, meaning beat closes the current reduction group.
REQ-010 SHALL have port o_valid, output, 1 bit, meaning group result present.
REQ-011 SHALL have port i_ready, input, 1 bit, meaning downstream accepts the result.
REQ-012 SHALL have port o_max_exp, output, EW bits, meaning group maximum exponent.
REQ-013 SHALL have port o_max_idx, output, IDX_W bits, meaning winning lane index.
REQ-014 SHALL have port o_beats, output, 8 bits, meaning beats in the group, saturating at 255.
REQ-015 SHALL have port number, output, 51 bits, meaning static gate-count estimate.

Function
REQ-016 SHALL compute per-beat max through a binary comparator tree of D = $clog2(NUM_IN) levels, each level registered.
REQ-017 SHALL pass odd-count leftover nodes to the next level unchanged, through a register.
REQ-018 SHALL resolve ties at every node to the lower lane index.
REQ-019 SHALL compare exponents as unsigned EW-bit values.
REQ-020 SHALL follow the tree with one accumulator stage holding running max, index and beat count for the open group.
REQ-021 SHALL, for the first beat of a group, load the beat result into the accumulator.
REQ-022 SHALL, for later beats, replace the accumulator only when the beat max is strictly greater, so ties keep the earlier beat.
REQ-023 SHALL, on a beat carrying i_last, present the accumulated result with o_valid=1; latency is D+1 cycles from acceptance with no stall.
REQ-024 SHALL treat a beat as accepted when i_valid && o_ready.
REQ-025 SHALL drive o_ready = !(o_valid && !i_ready); a stall freezes all pipeline registers and valid bits.
REQ-026 SHALL hold o_valid and its data stable until i_ready=1.
REQ-027 SHALL sustain one beat per cycle when i_ready stays 1.
REQ-028 SHALL keep a result being handed off (o_valid && i_ready) and a new group's first beat reaching the accumulator in the same cycle independent, so neither is lost.
REQ-029 SHALL ignore i_exp and i_last whenever i_valid=0; bubbles propagate as invalid stages.
REQ-030 SHALL drive number with a constant sum of sub-module estimates plus register cost, not varying with data.

Reset
REQ-031 SHALL, on i_rst=1, asynchronously clear all stage valids, the accumulator, o_valid, o_max_exp, o_max_idx and o_beats to 0; o_ready then reads 1.
REQ-032 SHALL discard an open group that reset interrupts, with no partial result emitted after reset release.
REQ-033 SHALL treat the first accepted beat after reset as the first beat of a new group.

Structure
REQ-034 SHALL take EW and the tree-depth function from the shared package max_exp_pkg, together with the gate-cost constants for the comparator, mux and flop.
REQ-035 SHALL build each tree node from sub-module max_exp_cmp2 (COM6 + MX, returning max, index and number), instanced NUM_IN-1 times.

Verification
REQ-036 SHALL verify NUM_IN=9 with a single beat of lanes 3,17,5,17,0,9,1,2,4 and last=1 -> after 5 cycles, max 17, idx 1, beats 1.
REQ-037 SHALL verify a group of 3 beats with maxima 10, 31 (lane 6) and 31 (lane 0), last on beat 3 -> max 31, idx 6, beats 3, one o_valid pulse.
REQ-038 SHALL verify back-to-back single-beat groups with i_ready=1 -> one result per cycle, in order.
REQ-039 SHALL verify i_ready held at 0 for 4 cycles while results are pending -> o_ready=0, output stable, no loss or duplication after release.
REQ-040 SHALL verify i_rst pulsed in mid-group (after 2 beats), then a 1-beat group of all 63s -> only max 63, idx 0, beats 1 is emitted.
REQ-041 SHALL verify 300 beats with last only on the final beat -> o_beats=255 at saturation.
